// File: rtl/cordic_phase_freq.sv
// Phase unwrap and frequency averaging stage behind the 11-stage CORDIC arctangent pipeline.
// Optional stage-A phase output enabled by defining CORDIC_FREQ_PHASE_OUT_EN.
module cordic_phase_freq #(
  parameter int unsigned LAT      = 11,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned PI_Q     = 3217
) (
  input  logic               rx_clk,
  input  logic               rx_rst,
  input  logic               rx_valid,
  input  logic               rx_flip,
  input  logic               rx_clear,
  input  logic signed [11:0] rx_z,
  output logic signed [12:0] tx_freq,
  output logic               tx_valid
`ifdef CORDIC_FREQ_PHASE_OUT_EN
  ,
  output logic signed [12:0] tx_phase,
  output logic               tx_phase_valid
`endif
);

  localparam int unsigned Z_W   = 12;
  localparam int unsigned PH_W  = 13;
  localparam int unsigned D_W   = 14;
  localparam int unsigned ACC_W = D_W + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2;

  localparam logic signed [PH_W-1:0] PI_P     = PH_W'(PI_Q);
  localparam logic signed [D_W-1:0]  PI_D     = D_W'(PI_Q);
  localparam logic signed [D_W-1:0]  TWO_PI_D = D_W'(2 * PI_Q);
  localparam logic [CNT_W-1:0]       CNT_MAX  = '1;

  typedef enum logic {EMPTY, RUN} state_t;

  logic [LAT-1:0]           dl_v;
  logic [LAT-1:0]           dl_f;
  logic                     dv;
  logic                     df;
  logic signed [PH_W-1:0]   z_ext;
  logic signed [PH_W-1:0]   phase_c;
  logic signed [PH_W-1:0]   phase_a;
  logic                     phase_v;
  logic signed [PH_W-1:0]   prev;
  state_t                   state;
  state_t                   state_nxt;
  logic                     diff_en;
  logic signed [D_W-1:0]    d_raw;
  logic signed [D_W-1:0]    d_wrap;
  logic signed [D_W-1:0]    d_reg;
  logic                     d_v;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum_c;
  logic [CNT_W-1:0]         cnt;

  // Valid/fold flags ride alongside the CORDIC so they line up with rx_z.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      dl_v <= '0;
      dl_f <= '0;
    end else if (rx_clear) begin
      dl_v <= '0;
      dl_f <= '0;
    end else begin
      dl_v <= {dl_v[LAT-2:0], rx_valid};
      dl_f <= {dl_f[LAT-2:0], rx_flip};
    end
  end

  assign dv = dl_v[LAT-1];
  assign df = dl_f[LAT-1];

  // Undo the x<0 fold: rotate the half-plane angle by pi toward zero.
  always_comb begin
    z_ext = PH_W'(rx_z);
    if (!df) begin
      phase_c = z_ext;
    end else if (!rx_z[Z_W-1]) begin
      phase_c = z_ext - PI_P;
    end else begin
      phase_c = z_ext + PI_P;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      phase_a <= '0;
      phase_v <= 1'b0;
    end else if (rx_clear) begin
      phase_a <= '0;
      phase_v <= 1'b0;
    end else begin
      phase_v <= dv;
      if (dv) begin
        phase_a <= phase_c;
      end
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      state <= EMPTY;
    end else if (rx_clear) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // The first phase after a flush has no predecessor, so it only primes prev.
  always_comb begin
    state_nxt = state;
    diff_en   = 1'b0;
    if (phase_v) begin
      case (state)
        EMPTY:   state_nxt = RUN;
        RUN:     diff_en   = 1'b1;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Phase difference folded into [-pi, +pi]; exactly +/-pi is left alone.
  always_comb begin
    d_raw  = D_W'(phase_a) - D_W'(prev);
    d_wrap = d_raw;
    if (d_raw > PI_D) begin
      d_wrap = d_raw - TWO_PI_D;
    end else if (d_raw < -PI_D) begin
      d_wrap = d_raw + TWO_PI_D;
    end
  end

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      prev  <= '0;
      d_reg <= '0;
      d_v   <= 1'b0;
    end else if (rx_clear) begin
      prev  <= '0;
      d_reg <= '0;
      d_v   <= 1'b0;
    end else begin
      d_v <= diff_en;
      if (diff_en) begin
        d_reg <= d_wrap;
      end
      if (phase_v) begin
        prev <= phase_a;
      end
    end
  end

  assign sum_c = acc + ACC_W'(d_reg);

  // Accumulate 2^AVG_LOG2 differences, then emit the floored mean.
  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      acc      <= '0;
      cnt      <= '0;
      tx_freq  <= '0;
      tx_valid <= 1'b0;
    end else if (rx_clear) begin
      acc      <= '0;
      cnt      <= '0;
      tx_freq  <= '0;
      tx_valid <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (d_v) begin
        if (cnt == CNT_MAX) begin
          tx_freq  <= PH_W'(sum_c >>> AVG_LOG2);
          tx_valid <= 1'b1;
          acc      <= '0;
          cnt      <= '0;
        end else begin
          acc <= sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef CORDIC_FREQ_PHASE_OUT_EN
  assign tx_phase       = phase_a;
  assign tx_phase_valid = phase_v;
`endif

endmodule

// File: tb/tb_cordic_phase_freq.sv
// Scoreboard bench for cordic_phase_freq: directed cases plus randomized samples, clears and resets.
module tb_cordic_phase_freq;
  localparam int LAT      = 11;
  localparam int AVG_LOG2 = 2;
  localparam int NAVG     = 1 << AVG_LOG2;
  localparam int PI       = 3217;

  logic               rx_clk   = 1'b0;
  logic               rx_rst   = 1'b0;
  logic               rx_valid = 1'b0;
  logic               rx_flip  = 1'b0;
  logic               rx_clear = 1'b0;
  logic signed [11:0] rx_z     = '0;
  logic signed [12:0] tx_freq;
  logic               tx_valid;
`ifdef CORDIC_FREQ_PHASE_OUT_EN
  logic signed [12:0] tx_phase;
  logic               tx_phase_valid;
`endif

  cordic_phase_freq #(.LAT(LAT), .AVG_LOG2(AVG_LOG2), .PI_Q(PI)) dut (
    .rx_clk   (rx_clk),
    .rx_rst   (rx_rst),
    .rx_valid (rx_valid),
    .rx_flip  (rx_flip),
    .rx_clear (rx_clear),
    .rx_z     (rx_z),
    .tx_freq  (tx_freq),
    .tx_valid (tx_valid)
`ifdef CORDIC_FREQ_PHASE_OUT_EN
    ,
    .tx_phase       (tx_phase),
    .tx_phase_valid (tx_phase_valid)
`endif
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  typedef struct { int t; int ph; } pend_t;
  typedef struct { int t; int f; }  exp_t;

  pend_t pend[$];
  exp_t  expq[$];
  int    zs[LAT];
  int    n_chk = 0;
  int    n_err = 0;
  bit    have_prev = 0;
  int    prev_ph = 0;
  int    acc_sum = 0;
  int    n_diff = 0;
  int    hold_f = 0;

  task automatic check(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic int phase_of(input int z, input bit f);
    if (!f) return z;
    if (z >= 0) return z - PI;
    return z + PI;
  endfunction

  function automatic int floor_div(input int s);
    int q;
    q = s / NAVG;
    if ((s % NAVG != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic flush();
    pend.delete();
    have_prev = 0;
    acc_sum   = 0;
    n_diff    = 0;
    hold_f    = 0;
  endtask

  // Phase reaches the accumulator LAT+2 cycles after issue; result strobes one cycle later.
  task automatic commit(input int ph);
    int d;
    if (!have_prev) begin
      have_prev = 1;
      prev_ph   = ph;
      return;
    end
    d = ph - prev_ph;
    prev_ph = ph;
    while (d > PI)  d -= 2 * PI;
    while (d < -PI) d += 2 * PI;
    acc_sum += d;
    n_diff++;
    if (n_diff == NAVG) begin
      hold_f = floor_div(acc_sum);
      expq.push_back('{t: cyc + 1, f: hold_f});
      acc_sum = 0;
      n_diff  = 0;
    end
  endtask

  task automatic step(input bit v, input bit f, input int z, input bit clr);
    int    slot;
    pend_t p;
    @(negedge rx_clk);
    rx_rst = 1'b1;
    slot = cyc % LAT;
    if (clr) begin
      flush();
    end else begin
      while (pend.size() > 0 && pend[0].t + LAT + 2 == cyc) begin
        p = pend.pop_front();
        commit(p.ph);
      end
      if (v) pend.push_back('{t: cyc, ph: phase_of(z, f)});
    end
    rx_valid = v;
    rx_flip  = f;
    rx_clear = clr;
    rx_z     = 12'(zs[slot]);
    zs[slot] = v ? z : (int'($urandom_range(3216, 0)) - 1608);
  endtask

  task automatic samp(input int p);
    if (p >= -1608 && p <= 1608) step(1'b1, 1'b0, p, 1'b0);
    else if (p > 0)              step(1'b1, 1'b1, p - PI, 1'b0);
    else                         step(1'b1, 1'b1, p + PI, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge rx_clk);
    rx_rst   = 1'b0;
    rx_valid = 1'b0;
    rx_clear = 1'b0;
    flush();
    #1;
    check("rst_valid", int'(tx_valid), 0);
    check("rst_freq", int'(tx_freq), 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard in value and cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge rx_clk);
      #1;
      while (expq.size() > 0 && expq[0].t < cyc) begin
        e = expq.pop_front();
        check("missing_valid", 0, e.f);
      end
      if (tx_valid) begin
        if (expq.size() == 0) begin
          check("spurious_valid", int'(tx_freq), 99999);
        end else begin
          e = expq.pop_front();
          check("valid_cycle", cyc, e.t);
          check("freq", int'(tx_freq), e.f);
        end
      end
    end
  end

  initial begin
    int r;
    for (int i = 0; i < LAT; i++) zs[i] = 0;
    @(posedge rx_clk);
    #1;
    check("reset_valid", int'(tx_valid), 0);
    check("reset_freq", int'(tx_freq), 0);

    // constant step of 100
    for (int i = 0; i < 5; i++) samp(i * 100);
    idle(LAT + 6);
    // difference wrapping past -pi
    samp(3100); samp(-3134); samp(-2934); samp(-2734); samp(-2534);
    idle(LAT + 6);
    // folded samples, difference wraps past +pi
    step(1'b1, 1'b1, 1000, 1'b0); step(1'b1, 1'b1, -1000, 1'b0);
    samp(217); samp(-1783); samp(2217);
    idle(LAT + 6);
    // negative mean with floor and input gaps
    samp(0); idle(1); samp(-3); idle(3); samp(-6); samp(-9); idle(2); samp(-11);
    idle(LAT + 6);
    // exactly +/-pi differences are not wrapped
    samp(-1609); samp(1608); samp(-1609); samp(1608); samp(1600);
    idle(LAT + 6);
    // clear with samples in flight drops them
    samp(0); samp(10); samp(20);
    idle(LAT + 3);
    samp(30); samp(40); samp(50);
    step(1'b0, 1'b0, 0, 1'b1);
    @(posedge rx_clk);
    #1;
    check("clear_freq", int'(tx_freq), 0);
    for (int i = 0; i < 5; i++) samp(i * 50);
    idle(LAT + 6);
    // async reset mid-run
    samp(0); samp(77); samp(154);
    idle(4);
    do_reset();
    for (int i = 0; i < 5; i++) samp(500 + i * 10);
    idle(LAT + 6);

    // randomized samples, gaps, clears and resets
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(199, 0));
      if (r == 0)      do_reset();
      else if (r < 4)  step(1'b1, 1'($urandom_range(1, 0)), 0, 1'b1);
      else if (r < 60) idle(int'($urandom_range(3, 1)));
      else step(1'b1, 1'($urandom_range(1, 0)), int'($urandom_range(3216, 0)) - 1608, 1'b0);
    end
    idle(LAT + 8);
    check("final_queue_empty", expq.size(), 0);
    check("final_hold", int'(tx_freq), hold_f);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
